// File: rtl/npu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | npu_pkg                                                              |
// | Shared types and memory-width constants for the NPU instruction path |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package npu_pkg;

  localparam int FRAM_AW_DEFAULT = 20;
  localparam int KRAM_AW_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_ISSUE = 2'd2
  } instgen_state_t;

  typedef enum logic {
    LOOP_ROW_OUTER = 1'b0,
    LOOP_GRP_OUTER = 1'b1
  } loop_order_e;

endpackage
`default_nettype wire

// File: rtl/instgen_loop_ctr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instgen_loop_ctr                                                     |
// | Wrap counter with NUM_ACC add-only accumulators that reload on wrap  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module instgen_loop_ctr #(
  parameter int CNT_W   = 32,
  parameter int ACC_W   = 32,
  parameter int NUM_ACC = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     inc,
  input  logic [CNT_W-1:0]         limit,
  input  logic [NUM_ACC*ACC_W-1:0] init,
  input  logic [NUM_ACC*ACC_W-1:0] step,
  output logic [CNT_W-1:0]         count_next,
  output logic [NUM_ACC*ACC_W-1:0] acc_next,
  output logic                     last
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign last       = (cnt_q == limit - CNT_W'(1));
  assign count_next = cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = last ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Each accumulator tracks init + count*step; the wrap reloads init instead of multiplying.
  for (genvar i = 0; i < NUM_ACC; i++) begin : g_acc
    logic [ACC_W-1:0] acc_q, acc_d, init_w, step_w;

    assign init_w = init[i*ACC_W +: ACC_W];
    assign step_w = step[i*ACC_W +: ACC_W];

    always_comb begin
      acc_d = acc_q;
      if (clear) begin
        acc_d = init_w;
      end else if (inc) begin
        acc_d = last ? init_w : acc_q + step_w;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc_q <= '0;
      end else begin
        acc_q <= acc_d;
      end
    end

    assign acc_next[i*ACC_W +: ACC_W] = acc_d;
  end

endmodule
`default_nettype wire

// File: rtl/conv_tile_instgen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | conv_tile_instgen                                                    |
// | Walks output rows x channel groups of a layer, one instruction each  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module conv_tile_instgen
  import npu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FRAM_AW    = FRAM_AW_DEFAULT,
  parameter int KRAM_AW    = KRAM_AW_DEFAULT,
  parameter int NUM_PE     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] feature_baseaddr,
  input  logic [ADDR_WIDTH-1:0] kernel_baseaddr,
  input  logic [ADDR_WIDTH-1:0] output_baseaddr,
  input  logic [DATA_WIDTH-1:0] feature_width,
  input  logic [DATA_WIDTH-1:0] feature_chin,
  input  logic [DATA_WIDTH-1:0] feature_chout,
  input  logic [DATA_WIDTH-1:0] output_width,
  input  logic [DATA_WIDTH-1:0] output_height,
  input  logic [7:0]            kernel_sizeh,
  input  logic [7:0]            kernel_sizew,
  input  logic [7:0]            stride,
  input  logic                  has_bias,
  input  logic                  has_relu,
  input  logic                  loop_order,
  input  logic                  csrcmd_valid,
  output logic                  instgen_ready,
  input  logic                  abort,
  output logic [FRAM_AW-1:0]    stride_feature_baseaddr,
  output logic [KRAM_AW-1:0]    stride_kernel_baseaddr,
  output logic [FRAM_AW-1:0]    stride_wb_baseaddr,
  output logic [DATA_WIDTH-1:0] stride_feature_chin,
  output logic [DATA_WIDTH-1:0] stride_feature_chout,
  output logic [DATA_WIDTH-1:0] stride_feature_width,
  output logic [DATA_WIDTH-1:0] stride_feature_height,
  output logic [DATA_WIDTH-1:0] stride_wb_ch_offset,
  output logic [7:0]            stride_kernel_sizeh,
  output logic [7:0]            stride_kernel_sizew,
  output logic                  stride_has_bias,
  output logic                  stride_has_relu,
  output logic                  inst_valid,
  output logic                  tlast,
  input  logic                  decoder_ready,
  output logic                  done
);

  localparam int                    PE_LOG = $clog2(NUM_PE);
  localparam logic [DATA_WIDTH-1:0] PE_W   = DATA_WIDTH'(NUM_PE);
  localparam logic [DATA_WIDTH-1:0] PE_NEG = DATA_WIDTH'(0) - DATA_WIDTH'(NUM_PE);

  instgen_state_t state_q, state_d;

  logic [FRAM_AW-1:0]    fbase_q, fbase_d, obase_q, obase_d;
  logic [KRAM_AW-1:0]    kbase_q, kbase_d;
  logic [DATA_WIDTH-1:0] fwidth_q, fwidth_d, chin_q, chin_d, chout_q, chout_d;
  logic [DATA_WIDTH-1:0] owidth_q, owidth_d, oheight_q, oheight_d;
  logic [7:0]            kh_q, kh_d, kw_q, kw_d, stride_q, stride_d;
  logic                  bias_q, bias_d, relu_q, relu_d;
  loop_order_e           order_q, order_d;

  logic [FRAM_AW-1:0]    row_step_q, row_step_d, wb_row_step_q, wb_row_step_d;
  logic [DATA_WIDTH-1:0] kgrp_step_q, kgrp_step_d;

  logic [FRAM_AW-1:0]    inst_fbase_q, inst_fbase_d, inst_wbbase_q, inst_wbbase_d;
  logic [KRAM_AW-1:0]    inst_kbase_q, inst_kbase_d;
  logic [DATA_WIDTH-1:0] inst_chin_q, inst_chin_d, inst_chout_q, inst_chout_d;
  logic [DATA_WIDTH-1:0] inst_width_q, inst_width_d, inst_height_q, inst_height_d;
  logic [DATA_WIDTH-1:0] inst_choff_q, inst_choff_d;
  logic [7:0]            inst_kh_q, inst_kh_d, inst_kw_q, inst_kw_d;
  logic                  inst_bias_q, inst_bias_d, inst_relu_q, inst_relu_d;
  logic                  inst_tlast_q, inst_tlast_d, inst_valid_q, inst_valid_d;
  logic                  done_q, done_d;

  logic                  hs, empty_w, load_fields, ctr_clear, advance;
  logic                  row_inc, grp_inc, row_last, grp_last, tlast_next;
  logic [DATA_WIDTH:0]   g_sum_w;
  logic [DATA_WIDTH-1:0] g_total_w, row_step_w, kgrp_w, wb_row_w;
  logic [DATA_WIDTH-1:0] oy_next, g_next, rem_next;
  logic [2*FRAM_AW-1:0]  row_acc_next;
  logic [3*DATA_WIDTH-1:0] grp_acc_next;
  logic                  unused_bits;

  // Shift-based ceil keeps the carry out of chout so large channel counts do not wrap.
  assign g_sum_w   = {1'b0, chout_q} + {1'b0, PE_W - DATA_WIDTH'(1)};
  assign g_total_w = DATA_WIDTH'(g_sum_w >> PE_LOG);

  assign row_step_w = DATA_WIDTH'(stride_q) * fwidth_q * chin_q;
  assign kgrp_w     = PE_W * (DATA_WIDTH'(kh_q) * DATA_WIDTH'(kw_q) * chin_q + DATA_WIDTH'(bias_q));
  assign wb_row_w   = owidth_q * chout_q;

  assign hs      = inst_valid_q && decoder_ready;
  assign empty_w = (oheight_q == '0) || (chout_q == '0);

  assign row_inc = advance && ((order_q == LOOP_GRP_OUTER) || grp_last);
  assign grp_inc = advance && ((order_q == LOOP_ROW_OUTER) || row_last);

  instgen_loop_ctr #(
    .CNT_W   (DATA_WIDTH),
    .ACC_W   (FRAM_AW),
    .NUM_ACC (2)
  ) u_row_ctr (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (ctr_clear),
    .inc        (row_inc),
    .limit      (oheight_q),
    .init       ({obase_q, fbase_q}),
    .step       ({wb_row_step_q, row_step_q}),
    .count_next (oy_next),
    .acc_next   (row_acc_next),
    .last       (row_last)
  );

  // Accumulators: kernel base, write-back channel offset, channels remaining.
  instgen_loop_ctr #(
    .CNT_W   (DATA_WIDTH),
    .ACC_W   (DATA_WIDTH),
    .NUM_ACC (3)
  ) u_grp_ctr (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (ctr_clear),
    .inc        (grp_inc),
    .limit      (g_total_w),
    .init       ({chout_q, DATA_WIDTH'(0), DATA_WIDTH'(kbase_q)}),
    .step       ({PE_NEG, PE_W, kgrp_step_q}),
    .count_next (g_next),
    .acc_next   (grp_acc_next),
    .last       (grp_last)
  );

  assign rem_next   = grp_acc_next[2*DATA_WIDTH +: DATA_WIDTH];
  assign tlast_next = (oy_next == oheight_q - DATA_WIDTH'(1)) &&
                      (g_next == g_total_w - DATA_WIDTH'(1));

  always_comb begin
    state_d       = state_q;
    fbase_d       = fbase_q;
    kbase_d       = kbase_q;
    obase_d       = obase_q;
    fwidth_d      = fwidth_q;
    chin_d        = chin_q;
    chout_d       = chout_q;
    owidth_d      = owidth_q;
    oheight_d     = oheight_q;
    kh_d          = kh_q;
    kw_d          = kw_q;
    stride_d      = stride_q;
    bias_d        = bias_q;
    relu_d        = relu_q;
    order_d       = order_q;
    row_step_d    = row_step_q;
    kgrp_step_d   = kgrp_step_q;
    wb_row_step_d = wb_row_step_q;
    inst_valid_d  = inst_valid_q;
    done_d        = 1'b0;
    load_fields   = 1'b0;
    ctr_clear     = 1'b0;
    advance       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (csrcmd_valid) begin
          fbase_d   = feature_baseaddr[FRAM_AW-1:0];
          kbase_d   = kernel_baseaddr[KRAM_AW-1:0];
          obase_d   = output_baseaddr[FRAM_AW-1:0];
          fwidth_d  = feature_width;
          chin_d    = feature_chin;
          chout_d   = feature_chout;
          owidth_d  = output_width;
          oheight_d = output_height;
          kh_d      = kernel_sizeh;
          kw_d      = kernel_sizew;
          stride_d  = stride;
          bias_d    = has_bias;
          relu_d    = has_relu;
          order_d   = loop_order_e'(loop_order);
          state_d   = ST_SETUP;
        end
      end
      ST_SETUP: begin
        ctr_clear     = 1'b1;
        row_step_d    = row_step_w[FRAM_AW-1:0];
        kgrp_step_d   = kgrp_w;
        wb_row_step_d = wb_row_w[FRAM_AW-1:0];
        if (abort || empty_w) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d      = ST_ISSUE;
          inst_valid_d = 1'b1;
          load_fields  = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (abort || (hs && inst_tlast_q)) begin
          state_d      = ST_IDLE;
          inst_valid_d = 1'b0;
          done_d       = 1'b1;
        end else if (hs) begin
          advance     = 1'b1;
          load_fields = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    inst_fbase_d  = inst_fbase_q;
    inst_kbase_d  = inst_kbase_q;
    inst_wbbase_d = inst_wbbase_q;
    inst_chin_d   = inst_chin_q;
    inst_chout_d  = inst_chout_q;
    inst_width_d  = inst_width_q;
    inst_height_d = inst_height_q;
    inst_choff_d  = inst_choff_q;
    inst_kh_d     = inst_kh_q;
    inst_kw_d     = inst_kw_q;
    inst_bias_d   = inst_bias_q;
    inst_relu_d   = inst_relu_q;
    inst_tlast_d  = inst_tlast_q;
    if (load_fields) begin
      inst_fbase_d  = row_acc_next[FRAM_AW-1:0];
      inst_kbase_d  = grp_acc_next[KRAM_AW-1:0];
      inst_wbbase_d = row_acc_next[2*FRAM_AW-1:FRAM_AW] + grp_acc_next[DATA_WIDTH +: FRAM_AW];
      inst_chout_d  = (rem_next < PE_W) ? rem_next : PE_W;
      inst_chin_d   = chin_q;
      inst_width_d  = fwidth_q;
      inst_height_d = DATA_WIDTH'(kh_q);
      inst_choff_d  = chout_q;
      inst_kh_d     = kh_q;
      inst_kw_d     = kw_q;
      inst_bias_d   = bias_q;
      inst_relu_d   = relu_q;
      inst_tlast_d  = tlast_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      fbase_q       <= '0;
      kbase_q       <= '0;
      obase_q       <= '0;
      fwidth_q      <= '0;
      chin_q        <= '0;
      chout_q       <= '0;
      owidth_q      <= '0;
      oheight_q     <= '0;
      kh_q          <= '0;
      kw_q          <= '0;
      stride_q      <= '0;
      bias_q        <= 1'b0;
      relu_q        <= 1'b0;
      order_q       <= LOOP_ROW_OUTER;
      row_step_q    <= '0;
      kgrp_step_q   <= '0;
      wb_row_step_q <= '0;
      inst_fbase_q  <= '0;
      inst_kbase_q  <= '0;
      inst_wbbase_q <= '0;
      inst_chin_q   <= '0;
      inst_chout_q  <= '0;
      inst_width_q  <= '0;
      inst_height_q <= '0;
      inst_choff_q  <= '0;
      inst_kh_q     <= '0;
      inst_kw_q     <= '0;
      inst_bias_q   <= 1'b0;
      inst_relu_q   <= 1'b0;
      inst_tlast_q  <= 1'b0;
      inst_valid_q  <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      fbase_q       <= fbase_d;
      kbase_q       <= kbase_d;
      obase_q       <= obase_d;
      fwidth_q      <= fwidth_d;
      chin_q        <= chin_d;
      chout_q       <= chout_d;
      owidth_q      <= owidth_d;
      oheight_q     <= oheight_d;
      kh_q          <= kh_d;
      kw_q          <= kw_d;
      stride_q      <= stride_d;
      bias_q        <= bias_d;
      relu_q        <= relu_d;
      order_q       <= order_d;
      row_step_q    <= row_step_d;
      kgrp_step_q   <= kgrp_step_d;
      wb_row_step_q <= wb_row_step_d;
      inst_fbase_q  <= inst_fbase_d;
      inst_kbase_q  <= inst_kbase_d;
      inst_wbbase_q <= inst_wbbase_d;
      inst_chin_q   <= inst_chin_d;
      inst_chout_q  <= inst_chout_d;
      inst_width_q  <= inst_width_d;
      inst_height_q <= inst_height_d;
      inst_choff_q  <= inst_choff_d;
      inst_kh_q     <= inst_kh_d;
      inst_kw_q     <= inst_kw_d;
      inst_bias_q   <= inst_bias_d;
      inst_relu_q   <= inst_relu_d;
      inst_tlast_q  <= inst_tlast_d;
      inst_valid_q  <= inst_valid_d;
      done_q        <= done_d;
    end
  end

  assign instgen_ready           = (state_q == ST_IDLE);
  assign stride_feature_baseaddr = inst_fbase_q;
  assign stride_kernel_baseaddr  = inst_kbase_q;
  assign stride_wb_baseaddr      = inst_wbbase_q;
  assign stride_feature_chin     = inst_chin_q;
  assign stride_feature_chout    = inst_chout_q;
  assign stride_feature_width    = inst_width_q;
  assign stride_feature_height   = inst_height_q;
  assign stride_wb_ch_offset     = inst_choff_q;
  assign stride_kernel_sizeh     = inst_kh_q;
  assign stride_kernel_sizew     = inst_kw_q;
  assign stride_has_bias         = inst_bias_q;
  assign stride_has_relu         = inst_relu_q;
  assign inst_valid              = inst_valid_q;
  assign tlast                   = inst_tlast_q;
  assign done                    = done_q;

  // Truncated address bits and wide products are intentionally dropped.
  assign unused_bits = ^{feature_baseaddr, kernel_baseaddr, output_baseaddr,
                         row_step_w, wb_row_w, grp_acc_next, g_sum_w};

endmodule
`default_nettype wire

// File: tb/tb_conv_tile_instgen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_conv_tile_instgen                                                 |
// | Scoreboard bench: reference loop nest vs. issued instruction stream  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_conv_tile_instgen;

  localparam int    NPE   = 8;
  localparam longint FMASK = (64'd1 << 20) - 1;
  localparam longint KMASK = (64'd1 << 16) - 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] feature_baseaddr, kernel_baseaddr, output_baseaddr;
  logic [31:0] feature_width, feature_chin, feature_chout, output_width, output_height;
  logic [7:0]  kernel_sizeh, kernel_sizew, stride;
  logic        has_bias, has_relu, loop_order, csrcmd_valid, abort, decoder_ready;
  logic        instgen_ready, inst_valid, tlast, done;
  logic [19:0] stride_feature_baseaddr, stride_wb_baseaddr;
  logic [15:0] stride_kernel_baseaddr;
  logic [31:0] stride_feature_chin, stride_feature_chout, stride_feature_width;
  logic [31:0] stride_feature_height, stride_wb_ch_offset;
  logic [7:0]  stride_kernel_sizeh, stride_kernel_sizew;
  logic        stride_has_bias, stride_has_relu;

  conv_tile_instgen #(
    .ADDR_WIDTH (32), .DATA_WIDTH (32), .FRAM_AW (20), .KRAM_AW (16), .NUM_PE (NPE)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .feature_baseaddr (feature_baseaddr), .kernel_baseaddr (kernel_baseaddr),
    .output_baseaddr (output_baseaddr), .feature_width (feature_width),
    .feature_chin (feature_chin), .feature_chout (feature_chout),
    .output_width (output_width), .output_height (output_height),
    .kernel_sizeh (kernel_sizeh), .kernel_sizew (kernel_sizew), .stride (stride),
    .has_bias (has_bias), .has_relu (has_relu), .loop_order (loop_order),
    .csrcmd_valid (csrcmd_valid), .instgen_ready (instgen_ready), .abort (abort),
    .stride_feature_baseaddr (stride_feature_baseaddr),
    .stride_kernel_baseaddr (stride_kernel_baseaddr),
    .stride_wb_baseaddr (stride_wb_baseaddr),
    .stride_feature_chin (stride_feature_chin), .stride_feature_chout (stride_feature_chout),
    .stride_feature_width (stride_feature_width), .stride_feature_height (stride_feature_height),
    .stride_wb_ch_offset (stride_wb_ch_offset),
    .stride_kernel_sizeh (stride_kernel_sizeh), .stride_kernel_sizew (stride_kernel_sizew),
    .stride_has_bias (stride_has_bias), .stride_has_relu (stride_has_relu),
    .inst_valid (inst_valid), .tlast (tlast), .decoder_ready (decoder_ready), .done (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Layer configuration used both to drive the DUT and to build expectations.
  longint c_fb, c_kb, c_ob, c_fw, c_chin, c_chout, c_ow, c_oh, c_kh, c_kw, c_st, c_bias, c_relu;
  bit     c_order;

  typedef struct {
    longint f;
    longint k;
    longint wb;
    longint ch;
    bit     tl;
  } exp_t;
  exp_t sb[$];

  task automatic set_cfg(input longint fb, kb, ob, fw, chin, chout, ow, oh, kh, kw, st,
                         input longint bias, relu, input bit order);
    c_fb = fb; c_kb = kb; c_ob = ob; c_fw = fw; c_chin = chin; c_chout = chout;
    c_ow = ow; c_oh = oh; c_kh = kh; c_kw = kw; c_st = st; c_bias = bias;
    c_relu = relu; c_order = order;
    feature_baseaddr = 32'(fb); kernel_baseaddr = 32'(kb); output_baseaddr = 32'(ob);
    feature_width = 32'(fw); feature_chin = 32'(chin); feature_chout = 32'(chout);
    output_width = 32'(ow); output_height = 32'(oh);
    kernel_sizeh = 8'(kh); kernel_sizew = 8'(kw); stride = 8'(st);
    has_bias = bias[0]; has_relu = relu[0]; loop_order = order;
  endtask

  task automatic push_one(input longint oy, input longint g, input longint gt);
    exp_t e;
    e.f  = (c_fb + oy * c_st * c_fw * c_chin) & FMASK;
    e.k  = (c_kb + g * NPE * (c_kh * c_kw * c_chin + c_bias)) & KMASK;
    e.wb = (c_ob + oy * c_ow * c_chout + g * NPE) & FMASK;
    e.ch = (c_chout - g * NPE < NPE) ? c_chout - g * NPE : NPE;
    e.tl = (oy == c_oh - 1) && (g == gt - 1);
    sb.push_back(e);
  endtask

  task automatic push_layer();
    longint gt;
    gt = (c_chout + NPE - 1) / NPE;
    if (!c_order) begin
      for (longint oy = 0; oy < c_oh; oy++)
        for (longint g = 0; g < gt; g++) push_one(oy, g, gt);
    end else begin
      for (longint g = 0; g < gt; g++)
        for (longint oy = 0; oy < c_oh; oy++) push_one(oy, g, gt);
    end
  endtask

  // Monitor state
  bit          mon_en = 1'b0;
  int          hs_cnt, valid_cnt, done_cnt, first_valid_cyc, last_hs_cyc, done_cyc, cmd_cyc;
  bit          stall_prev;
  logic [19:0] h_f, h_wb;
  logic [15:0] h_k;
  logic [31:0] h_ch;
  logic        h_tl;
  exp_t        got;

  task automatic clear_stats();
    hs_cnt = 0; valid_cnt = 0; done_cnt = 0; stall_prev = 1'b0;
    first_valid_cyc = -1; last_hs_cyc = -1; done_cyc = -1;
  endtask

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (inst_valid) begin
        valid_cnt++;
        if (valid_cnt == 1) first_valid_cyc = cyc;
      end
      if (stall_prev && inst_valid) begin
        check("hold_fbase", stride_feature_baseaddr, h_f);
        check("hold_kbase", stride_kernel_baseaddr, h_k);
        check("hold_wbbase", stride_wb_baseaddr, h_wb);
        check("hold_chout", stride_feature_chout, h_ch);
        check("hold_tlast", tlast, h_tl);
      end
      if (inst_valid && decoder_ready) begin
        hs_cnt++;
        last_hs_cyc = cyc;
        if (sb.size() == 0) begin
          check("unexpected_inst", 1, 0);
        end else begin
          got = sb.pop_front();
          check("fbase", stride_feature_baseaddr, got.f);
          check("kbase", stride_kernel_baseaddr, got.k);
          check("wbbase", stride_wb_baseaddr, got.wb);
          check("chout", stride_feature_chout, got.ch);
          check("tlast", tlast, got.tl);
          check("chin", stride_feature_chin, c_chin);
          check("width", stride_feature_width, c_fw);
          check("height", stride_feature_height, c_kh);
          check("wb_ch_off", stride_wb_ch_offset, c_chout);
          check("ksh", stride_kernel_sizeh, c_kh);
          check("ksw", stride_kernel_sizew, c_kw);
          check("bias", stride_has_bias, c_bias);
          check("relu", stride_has_relu, c_relu);
        end
      end
      stall_prev = inst_valid && !decoder_ready;
      h_f = stride_feature_baseaddr; h_k = stride_kernel_baseaddr;
      h_wb = stride_wb_baseaddr; h_ch = stride_feature_chout; h_tl = tlast;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("ready_at_done", instgen_ready, 1);
        check("valid_at_done", inst_valid, 0);
      end
    end
  end

  task automatic send_cmd();
    cmd_cyc = cyc;
    csrcmd_valid = 1'b1;
    @(posedge clk); #1;
    csrcmd_valid = 1'b0;
  endtask

  task automatic run_layer(input int stall_pct, input int exp_n);
    int n;
    clear_stats();
    push_layer();
    decoder_ready = 1'b1;
    send_cmd();
    n = 0;
    while (done_cnt == 0 && n < 400) begin
      decoder_ready = (stall_pct == 0) ? 1'b1 : ($urandom_range(0, 99) >= 32'(stall_pct));
      @(posedge clk); #1;
      n++;
    end
    if (done_cnt == 0) check("layer_timeout", 0, 1);
    decoder_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("hs_count", hs_cnt, exp_n);
    check("done_pulses", done_cnt, 1);
    check("sb_empty", sb.size(), 0);
    check("valid_latency", 64'(first_valid_cyc - cmd_cyc), 2);
    check("done_latency", 64'(done_cyc - last_hs_cyc), 1);
  endtask

  initial begin
    int n;
    csrcmd_valid = 1'b0; abort = 1'b0; decoder_ready = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
    clear_stats();
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", instgen_ready, 1);
    check("rst_valid", inst_valid, 0);
    check("rst_done", done, 0);
    check("rst_tlast", tlast, 0);
    check("rst_fbase", stride_feature_baseaddr, 0);
    check("rst_chout", stride_feature_chout, 0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Abort while idle has no effect
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("idle_abort_ready", instgen_ready, 1);
    check("idle_abort_done", done, 0);

    // Base layer, row-outer, no stalls
    set_cfg(32'h100, 0, 32'h8000, 20, 3, 32, 18, 8, 3, 3, 1, 1, 0, 1'b0);
    run_layer(0, 32);
    check("no_bubbles", 64'(last_hs_cyc - first_valid_cyc), 31);

    // Same layer, group-outer
    set_cfg(32'h100, 0, 32'h8000, 20, 3, 32, 18, 8, 3, 3, 1, 1, 1, 1'b1);
    run_layer(0, 32);

    // Partial last group and address wrap-around
    set_cfg(32'hFFFF0, 32'hFF00, 32'hFFFF8, 7, 5, 20, 4, 2, 2, 2, 2, 0, 1, 1'b0);
    run_layer(0, 6);

    // Random decoder stalls
    set_cfg(32'h240, 32'h10, 32'h400, 20, 3, 32, 18, 8, 3, 3, 1, 1, 0, 1'b0);
    run_layer(50, 32);

    // Abort after 5 handshakes, then restart
    set_cfg(32'h100, 0, 32'h8000, 20, 3, 32, 18, 8, 3, 3, 1, 1, 0, 1'b0);
    clear_stats();
    push_layer();
    decoder_ready = 1'b1;
    send_cmd();
    n = 0;
    while (hs_cnt < 5 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (hs_cnt < 5) check("abort_wait_timeout", 0, 1);
    decoder_ready = 1'b0;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort_valid_drop", inst_valid, 0);
    check("abort_done", done, 1);
    check("abort_ready", instgen_ready, 1);
    repeat (3) @(posedge clk);
    #1;
    check("abort_hs", hs_cnt, 5);
    check("abort_done_pulses", done_cnt, 1);
    sb.delete();
    run_layer(0, 32);

    // Empty layer
    set_cfg(32'h100, 0, 32'h8000, 20, 3, 32, 18, 0, 3, 3, 1, 1, 0, 1'b0);
    clear_stats();
    decoder_ready = 1'b1;
    send_cmd();
    repeat (5) @(posedge clk);
    #1;
    check("empty_valid", valid_cnt, 0);
    check("empty_done_pulses", done_cnt, 1);
    check("empty_done_latency", 64'(done_cyc - cmd_cyc), 2);

    // Reset in the middle of a layer
    set_cfg(32'h100, 0, 32'h8000, 20, 3, 32, 18, 8, 3, 3, 1, 1, 0, 1'b0);
    clear_stats();
    push_layer();
    decoder_ready = 1'b1;
    send_cmd();
    n = 0;
    while (hs_cnt < 3 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", inst_valid, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_tlast", tlast, 0);
    check("mid_rst_fbase", stride_feature_baseaddr, 0);
    check("mid_rst_kbase", stride_kernel_baseaddr, 0);
    check("mid_rst_wbbase", stride_wb_baseaddr, 0);
    check("mid_rst_ready", instgen_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.delete();
    clear_stats();
    mon_en = 1'b1;
    @(posedge clk); #1;
    set_cfg(32'hFFFF0, 32'hFF00, 32'hFFFF8, 7, 5, 20, 4, 2, 2, 2, 2, 0, 1, 1'b1);
    run_layer(0, 6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/conv_tile_instgen.md
# conv_tile_instgen

Parametrised instruction generator for the convolution NPU. It accepts one layer configuration from the CSR block and walks a two-level loop over output rows and output-channel groups of `NUM_PE` channels. Each iteration emits one stride instruction to the decoder over a valid/ready handshake. It generalises the single-mode generator with:
- a configurable PE group width;
- a selectable loop order;
- partial last channel groups;
- an explicit abort and a done pulse.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, CSR address width
- `DATA_WIDTH`, 32, CSR data width (`XLEN`)
- `FRAM_AW`, 20, feature RAM word-address width
- `KRAM_AW`, 16, kernel RAM word-address width
- `NUM_PE`, 8, output channels per instruction (power of two, 1..64)

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset
- `feature_baseaddr`, `kernel_baseaddr`, `output_baseaddr`  in  `ADDR_WIDTH` each  base addresses (word units; low `FRAM_AW`/`KRAM_AW` bits used)
- `feature_width`, `feature_chin`, `feature_chout`  in  `DATA_WIDTH` each  input feature map dimensions
- `output_width`, `output_height`  in  `DATA_WIDTH` each  output feature map dimensions
- `kernel_sizeh`, `kernel_sizew`, `stride`  in  8 each  kernel height, kernel width, convolution stride
- `has_bias`, `has_relu`  in  1 each  layer flags
- `loop_order`  in  1  0: row-outer/group-inner; 1: group-outer/row-inner
- `csrcmd_valid`  in  1  configuration valid
- `instgen_ready`  out  1  high only in IDLE
- `abort`  in  1  synchronous cancel of the current layer
- `stride_feature_baseaddr`  out  `FRAM_AW`  instruction feature base address
- `stride_kernel_baseaddr`  out  `KRAM_AW`  instruction kernel base address
- `stride_wb_baseaddr`  out  `FRAM_AW`  instruction write-back base address
- `stride_feature_chin`, `stride_feature_chout`, `stride_feature_width`, `stride_feature_height`, `stride_wb_ch_offset`  out  `DATA_WIDTH` each  instruction dimensions
- `stride_kernel_sizeh`, `stride_kernel_sizew`  out  8 each  kernel size
- `stride_has_bias`, `stride_has_relu`  out  1 each  layer flags
- `inst_valid`  out  1  instruction valid
- `tlast`  out  1  marks the last instruction of the layer
- `decoder_ready`  in  1  decoder accepts the instruction
- `done`  out  1  one-cycle pulse when the layer completes or is aborted

## Operation
- FSM states: IDLE → SETUP → ISSUE → IDLE.
- IDLE:
  - `instgen_ready=1`.
  - `csrcmd_valid` latches all configuration inputs into shadow registers, then the FSM goes to SETUP.
- SETUP (one cycle). The FSM computes:
  - `G = ceil(chout/NUM_PE)`
  - `row_step = stride*feature_width*chin`
  - `kgrp_step = NUM_PE*(kh*kw*chin + has_bias)`
  - `wb_row_step = output_width*chout`
  - It clears row counter `oy`, group counter `g` and the address accumulators.
  - If `output_height==0` or `chout==0`, it pulses `done` and returns to IDLE.
- ISSUE: instruction fields per (`oy`, `g`):
  - feature base = `fbase + oy*row_step`
  - kernel base = `kbase + g*kgrp_step`
  - wb base = `obase + oy*wb_row_step + g*NUM_PE`
  - `stride_feature_chout = min(NUM_PE, chout - g*NUM_PE)`
  - `stride_feature_height = kernel_sizeh`; `stride_wb_ch_offset = chout`
  - chin, width, kernel sizes and flags pass through from the shadow registers.
- Addresses are maintained by add-only accumulators. There are no multipliers in ISSUE.
- Counter advance on each handshake (`inst_valid && decoder_ready`):
  - `loop_order=0`: `g` increments and wraps to 0 at `G`; `oy` increments on the wrap.
  - `loop_order=1`: `oy` increments and wraps to 0 at `output_height`; `g` increments on the wrap.
- `tlast=1` when `oy==output_height-1` and `g==G-1`. A handshake with `tlast` ends the layer: FSM goes to IDLE and pulses `done` in the same cycle.
- `abort` in SETUP or ISSUE: FSM goes to IDLE next cycle, `inst_valid` drops, `done` pulses, and no further instruction is issued. `abort` in IDLE is ignored.
- Address arithmetic truncates to `FRAM_AW`/`KRAM_AW` (wrap-around, no error flag).

## Timing
- Reset:
  - FSM goes to IDLE, all counters and accumulators are cleared.
  - Every output is 0 except `instgen_ready=1`.
  - Reset mid-layer discards the layer.
- Handshake rules:
  - All instruction outputs are registered.
  - `inst_valid` rises one cycle after SETUP, i.e. 2 cycles after the `csrcmd_valid` cycle.
  - While `inst_valid && !decoder_ready`, all fields and `tlast` hold stable.
  - Back-to-back: with `decoder_ready` held high, one instruction issues per cycle with no bubbles.
  - `csrcmd_valid` outside IDLE is ignored.
- `done`:
  - On completion or abort in ISSUE, `done` is high the cycle after the final handshake or abort; `instgen_ready` rises in that same cycle.
  - On abort in SETUP, `done` is high the cycle after the abort.
  - On the empty-layer exit from SETUP, `done` is high the cycle after SETUP.

## Structure
- Shared package `npu_pkg`:
  - FSM state enum `instgen_state_t`
  - `loop_order_e`
  - FRAM/KRAM width constants
- One natural sub-module: `instgen_loop_ctr`, a parametrised wrap counter with an add-only address accumulator. It is instantiated twice, once for rows and once for groups.

## Test plan
- Base layer, `loop_order=0`, `decoder_ready=1`, `NUM_PE=8`. Config: 20×10×3 input, chout 32, 3×3 kernel, stride 1, out 18×8, bias on.
  - 32 instructions in consecutive cycles; `tlast` only on the 32nd; one `done` pulse.
  - `kgrp_step=224`, `row_step=60`, `wb_row_step=576`.
  - Instruction 2: kernel base 224, wb base `output_baseaddr+8`.
- Same layer with `loop_order=1` → the first 8 instructions are `g=0`, `oy=0..7`, with feature base stepping by 60.
- chout 20, `NUM_PE=8` → 3 groups; `stride_feature_chout` values are 8, 8, 4.
- Random `decoder_ready` stalls (~50%) → fields stable while stalled; total handshakes 32; no duplicate or missing (`oy`, `g`) pair.
- `abort` after 5 handshakes → `inst_valid` low next cycle, one `done` pulse, `instgen_ready=1`; a new `csrcmd_valid` restarts from `oy=0`, `g=0`.
- `output_height=0` → no `inst_valid`; `done` pulses 2 cycles after the command. `rst_n` asserted mid-layer → all outputs 0 immediately.
